matmul_mac_sequencer: RTL

Sequences one shared 4-bit unsigned multiplier (the team's `Four_B_Multiplier`) to compute an N×N matrix product C = A·B over 4-bit unsigned elements. Each multiply-accumulate takes one cycle. The block sits between the accelerator's operand load logic and the result writeback. It captures both operand matrices on `start`, iterates i/j/k with a state machine, accumulates partial products, and signals completion with a one-cycle `done` pulse.

---
 rtl/matmul_mac_sequencer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/matmul_mac_sequencer.sv
// matmul_mac_sequencer: computes C = A*B for NxN matrices of 4-bit unsigned
// elements by time-multiplexing one Four_B_Multiplier, one MAC per cycle.
// Operands are captured on start; results are published with a done pulse.
//
// Optional build macro: MATMUL_MULT_PIPE_EN
//   When defined, a register stage sits on the multiplier output. The
//   accumulator then consumes each product one cycle after issue, using
//   delayed i/j indices, and RUN takes one extra cycle to drain the last
//   product. Results are identical; done arrives one cycle later.
//
// Handshake: start is a level sampled only while IDLE; one sample launches
// one product. done is a single-cycle pulse coinciding with the cycle in
// which the new C_flat is first visible. busy is high whenever not IDLE.

// Shared 4x4 -> 8 bit unsigned multiplier.
module Four_B_Multiplier (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    assign p_o = {4'b0000, a_i} * {4'b0000, b_i};
endmodule

module matmul_mac_sequencer #(
    parameter  int N     = 2,
    localparam int ACC_W = 8 + $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N*N*4-1:0]       A_flat,
    input  logic [N*N*4-1:0]       B_flat,
    output logic                   busy,
    output logic                   done,
    output logic [N*N*ACC_W-1:0]   C_flat,
    output logic [1:0]             dbg_state
);

    localparam int OP_W  = N * N * 4;
    localparam int C_W   = N * N * ACC_W;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [C_W-1:0]     acc_q, acc_d;
    logic [C_W-1:0]     c_q, c_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [IDX_W-1:0]   k_q, k_d;

    logic [3:0]         a_sel;
    logic [3:0]         b_sel;
    logic [7:0]         mult_p;
    logic               issue;
    logic               last_idx;

    // Accumulate-side view: which product lands in which accumulator.
    logic               mac_v;
    logic [IDX_W-1:0]   mac_i;
    logic [IDX_W-1:0]   mac_j;
    logic [7:0]         mac_p;

`ifdef MATMUL_MULT_PIPE_EN
    logic [7:0]         prod_q, prod_d;
    logic               pv_q, pv_d;
    logic [IDX_W-1:0]   pi_q, pi_d;
    logic [IDX_W-1:0]   pj_q, pj_d;
    logic               drain_q, drain_d;
`endif

    // Operand selection from the captured copies for the current (i,j,k).
    always_comb begin
        a_sel = a_q[(int'(i_q) * N + int'(k_q)) * 4 +: 4];
        b_sel = b_q[(int'(k_q) * N + int'(j_q)) * 4 +: 4];
    end

    Four_B_Multiplier u_mult (
        .a_i (a_sel),
        .b_i (b_sel),
        .p_o (mult_p)
    );

    // Issue qualification and product routing into the accumulator bank.
    always_comb begin
        last_idx = (i_q == LAST) && (j_q == LAST) && (k_q == LAST);
`ifdef MATMUL_MULT_PIPE_EN
        issue = (state_q == S_RUN) && !drain_q;
        mac_v = pv_q;
        mac_i = pi_q;
        mac_j = pj_q;
        mac_p = prod_q;
`else
        issue = (state_q == S_RUN);
        mac_v = issue;
        mac_i = i_q;
        mac_j = j_q;
        mac_p = mult_p;
`endif
    end

    // Next-state logic: FSM transitions, index walk, accumulation, publish.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
`ifdef MATMUL_MULT_PIPE_EN
        prod_d  = mult_p;
        pv_d    = 1'b0;
        pi_d    = i_q;
        pj_d    = j_q;
        drain_d = drain_q;
`endif

        if (mac_v) begin
            acc_d[(int'(mac_i) * N + int'(mac_j)) * ACC_W +: ACC_W] =
                acc_q[(int'(mac_i) * N + int'(mac_j)) * ACC_W +: ACC_W]
                + {{(ACC_W - 8){1'b0}}, mac_p};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A_flat;
                    b_d     = B_flat;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = S_RUN;
`ifdef MATMUL_MULT_PIPE_EN
                    drain_d = 1'b0;
`endif
                end
            end

            S_RUN: begin
                if (issue) begin
                    // k innermost, then j, then i; all wrap to 0 after the last MAC.
                    if (k_q == LAST) begin
                        k_d = '0;
                        if (j_q == LAST) begin
                            j_d = '0;
                            i_d = (i_q == LAST) ? '0 : i_q + ONE;
                        end else begin
                            j_d = j_q + ONE;
                        end
                    end else begin
                        k_d = k_q + ONE;
                    end
`ifdef MATMUL_MULT_PIPE_EN
                    pv_d = 1'b1;
                    if (last_idx) begin
                        drain_d = 1'b1;
                    end
`else
                    if (last_idx) begin
                        // acc_d already holds the final MAC, so C is complete.
                        c_d     = acc_d;
                        state_d = S_DONE;
                    end
`endif
                end
`ifdef MATMUL_MULT_PIPE_EN
                if (drain_q) begin
                    // Last product has just been folded in via the pipe stage.
                    c_d     = acc_d;
                    drain_d = 1'b0;
                    state_d = S_DONE;
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

`ifdef MATMUL_MULT_PIPE_EN
    // Multiplier output stage with the indices that travel alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q  <= '0;
            pv_q    <= 1'b0;
            pi_q    <= '0;
            pj_q    <= '0;
            drain_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            pv_q    <= pv_d;
            pi_q    <= pi_d;
            pj_q    <= pj_d;
            drain_q <= drain_d;
        end
    end
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign C_flat    = c_q;
    assign dbg_state = state_q;

endmodule
